// File: rtl/gray_codec_pkg.sv
// Shared types and Gray-code helper functions for the Gray codec pipeline.
// Latency: n/a (package, combinational helpers only).
// Backpressure: n/a.
package gray_codec_pkg;

    localparam int MODE_BITS = 2;
    // Helpers operate on a fixed wide word; callers zero-extend narrower operands.
    localparam int MAX_W     = 64;

    typedef enum logic [MODE_BITS-1:0] {
        MODE_B2G  = 2'b00,
        MODE_G2B  = 2'b01,
        MODE_GINC = 2'b10,
        MODE_RSVD = 2'b11
    } mode_e;

    // Adjacent-XOR encode; zero upper bits leave the low WIDTH bits correct.
    function automatic logic [MAX_W-1:0] bin2gray(input logic [MAX_W-1:0] b);
        return b ^ (b >> 1);
    endfunction

    // Prefix-XOR decode from the MSB down; zero upper bits contribute nothing.
    function automatic logic [MAX_W-1:0] gray2bin(input logic [MAX_W-1:0] g);
        logic [MAX_W-1:0] b;
        b[MAX_W-1] = g[MAX_W-1];
        for (int i = MAX_W - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/gray_codec_pipe_stage.sv
// Generic valid/ready register slice carrying a W-bit payload.
// Latency: 1 cycle from acceptance to downstream valid.
// Backpressure: up_rdy = !dn_vld | dn_rdy (combinational pass-through of dn_rdy).
module gray_pipe_stage #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         up_vld,
    output logic         up_rdy,
    input  logic [W-1:0] up_dat,
    output logic         dn_vld,
    input  logic         dn_rdy,
    output logic [W-1:0] dn_dat
);

    // Slot can take a new word when empty or when its current word leaves this cycle.
    assign up_rdy = !dn_vld | dn_rdy;

    // Payload only loads on acceptance, so it stays frozen while stalled.
    always_ff @(posedge clk) begin
        if (rst) begin
            dn_vld <= 1'b0;
            dn_dat <= '0;
        end else if (up_rdy) begin
            dn_vld <= up_vld;
            if (up_vld) begin
                dn_dat <= up_dat;
            end
        end
    end

endmodule

// File: rtl/gray_codec_pipe.sv
// Two-stage Gray codec: binary->Gray, Gray->binary and Gray increment per transaction.
// Latency: 2 cycles from input acceptance to out_valid, 1 result per cycle sustained.
// Backpressure: valid/ready; holds 2 transactions, out_ready feeds in_ready combinationally.
module gray_codec_pipe
    import gray_codec_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int MODE_W = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [MODE_W-1:0] in_mode,
    input  logic [WIDTH-1:0]  in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WIDTH-1:0]  out_data,
    output logic [MODE_W-1:0] out_mode,
    output logic              out_err
);

    // S1 carries the mode plus the operand already in binary form where decoding is needed.
    typedef struct packed {
        mode_e            mode;
        logic [WIDTH-1:0] b;
    } s1_t;

    typedef struct packed {
        mode_e            mode;
        logic             err;
        logic [WIDTH-1:0] dat;
    } s2_t;

    s1_t              s1_nxt_dat;
    s1_t              s1_dat;
    s2_t              s2_nxt_dat;
    s2_t              s2_dat;
    logic             s1_vld;
    logic             s2_rdy;
    logic [WIDTH-1:0] ginc_n;

    // Stage 1 front end: decode Gray operands to binary, pass others through.
    always_comb begin
        s1_nxt_dat.mode = mode_e'(in_mode);
        s1_nxt_dat.b    = in_data;
        if (s1_nxt_dat.mode == MODE_G2B || s1_nxt_dat.mode == MODE_GINC) begin
            s1_nxt_dat.b = WIDTH'(gray2bin(MAX_W'(in_data)));
        end
    end

    gray_pipe_stage #(
        .W($bits(s1_t))
    ) u_s1 (
        .clk    (clk),
        .rst    (rst),
        .up_vld (in_valid),
        .up_rdy (in_ready),
        .up_dat (s1_nxt_dat),
        .dn_vld (s1_vld),
        .dn_rdy (s2_rdy),
        .dn_dat (s1_dat)
    );

    // Increment wraps modulo 2^WIDTH, so the all-ones binary value rolls to zero.
    assign ginc_n = s1_dat.b + WIDTH'(1);

    // Stage 2 front end: form the final result from the binary intermediate.
    always_comb begin
        s2_nxt_dat.mode = s1_dat.mode;
        s2_nxt_dat.err  = 1'b0;
        s2_nxt_dat.dat  = s1_dat.b;
        unique case (s1_dat.mode)
            MODE_B2G:  s2_nxt_dat.dat = WIDTH'(bin2gray(MAX_W'(s1_dat.b)));
            MODE_G2B:  s2_nxt_dat.dat = s1_dat.b;
            MODE_GINC: s2_nxt_dat.dat = WIDTH'(bin2gray(MAX_W'(ginc_n)));
            MODE_RSVD: s2_nxt_dat.err = 1'b1;
            default:   s2_nxt_dat.err = 1'b1;
        endcase
    end

    gray_pipe_stage #(
        .W($bits(s2_t))
    ) u_s2 (
        .clk    (clk),
        .rst    (rst),
        .up_vld (s1_vld),
        .up_rdy (s2_rdy),
        .up_dat (s2_nxt_dat),
        .dn_vld (out_valid),
        .dn_rdy (out_ready),
        .dn_dat (s2_dat)
    );

    assign out_data = s2_dat.dat;
    assign out_mode = MODE_W'(s2_dat.mode);
    assign out_err  = s2_dat.err;

endmodule

// File: tb/tb_gray_codec_pipe.sv
// Self-checking bench for gray_codec_pipe at WIDTH=8 (full) and WIDTH=16 (directed).
// Latency: n/a.
// Backpressure: exercised with stalls, full occupancy and random out_ready.
module tb_gray_codec_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready, out_valid, out_ready, out_err;
    logic [1:0]  in_mode, out_mode;
    logic [7:0]  in_data, out_data;

    logic        in_valid_w, in_ready_w, out_valid_w, out_ready_w, out_err_w;
    logic [1:0]  in_mode_w, out_mode_w;
    logic [15:0] in_data_w, out_data_w;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [63:0] d;
        logic [1:0]  m;
        logic        e;
    } exp_t;

    exp_t        q[$];
    logic [7:0]  seen[$];
    exp_t        e;
    logic        hold_v = 1'b0;
    logic [10:0] hold_val;
    logic [7:0]  vals[3] = '{8'h01, 8'h02, 8'h03};

    gray_codec_pipe #(.WIDTH(8), .MODE_W(2)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_mode(in_mode), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_mode(out_mode), .out_err(out_err)
    );

    gray_codec_pipe #(.WIDTH(16), .MODE_W(2)) dut_w (
        .clk(clk), .rst(rst),
        .in_valid(in_valid_w), .in_ready(in_ready_w), .in_mode(in_mode_w), .in_data(in_data_w),
        .out_valid(out_valid_w), .out_ready(out_ready_w), .out_data(out_data_w),
        .out_mode(out_mode_w), .out_err(out_err_w)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [63:0] mask(input int w);
        return (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
    endfunction

    function automatic logic [63:0] m_b2g(input logic [63:0] x, input int w);
        return (x ^ (x >> 1)) & mask(w);
    endfunction

    // Binary bit i is the XOR of all Gray bits at positions >= i.
    function automatic logic [63:0] m_g2b(input logic [63:0] g, input int w);
        logic [63:0] b = g & mask(w);
        for (int s = 1; s < w; s++) b = b ^ ((g & mask(w)) >> s);
        return b;
    endfunction

    function automatic exp_t model(input logic [1:0] m, input logic [63:0] d, input int w);
        exp_t r;
        r.m = m;
        r.e = (m == 2'b11);
        case (m)
            2'b00:   r.d = m_b2g(d, w);
            2'b01:   r.d = m_g2b(d, w);
            2'b10:   r.d = m_b2g((m_g2b(d, w) + 64'd1) & mask(w), w);
            default: r.d = d & mask(w);
        endcase
        return r;
    endfunction

    // ---------------- compare process (WIDTH=8) ----------------
    always @(negedge clk) begin
        if (rst) begin
            q.delete();
            hold_v = 1'b0;
        end else begin
            if (hold_v) begin
                chk("hold_valid", 64'(out_valid), 64'd1);
                chk("hold_payload", 64'({out_err, out_mode, out_data}), 64'(hold_val));
            end
            hold_v   = out_valid && !out_ready;
            hold_val = {out_err, out_mode, out_data};
            if (out_valid && out_ready) begin
                chk("model_has_entry", 64'(q.size() != 0), 64'd1);
                if (q.size() != 0) begin
                    e = q.pop_front();
                    chk("out_data", 64'(out_data), e.d);
                    chk("out_mode", 64'(out_mode), 64'(e.m));
                    chk("out_err", 64'(out_err), 64'(e.e));
                end
                seen.push_back(out_data);
            end
            if (in_valid && in_ready) q.push_back(model(in_mode, 64'(in_data), 8));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Single transaction into an empty pipe with out_ready high; checks literal result and latency.
    task automatic xact(input string nm, input logic [1:0] m, input logic [7:0] d,
                        input logic [7:0] ed, input logic ee);
        int n = 0;
        in_valid = 1'b1; in_mode = m; in_data = d; out_ready = 1'b1;
        @(negedge clk);
        chk({nm, "_accept"}, 64'(in_ready), 64'd1);
        tick();
        in_valid = 1'b0; in_data = 8'($urandom); in_mode = 2'($urandom);
        do begin
            @(negedge clk);
            n++;
        end while (!out_valid && n < 10);
        chk({nm, "_latency"}, 64'(n), 64'd2);
        chk({nm, "_data"}, 64'(out_data), 64'(ed));
        chk({nm, "_mode"}, 64'(out_mode), 64'(m));
        chk({nm, "_err"}, 64'(out_err), 64'(ee));
        tick();
    endtask

    task automatic xact_w(input string nm, input logic [1:0] m, input logic [15:0] d,
                          input logic [15:0] ed);
        int n = 0;
        in_valid_w = 1'b1; in_mode_w = m; in_data_w = d;
        @(negedge clk);
        chk({nm, "_accept"}, 64'(in_ready_w), 64'd1);
        tick();
        in_valid_w = 1'b0;
        do begin
            @(negedge clk);
            n++;
        end while (!out_valid_w && n < 10);
        chk({nm, "_latency"}, 64'(n), 64'd2);
        chk({nm, "_data"}, 64'(out_data_w), 64'(ed));
        chk({nm, "_mode"}, 64'(out_mode_w), 64'(m));
        chk({nm, "_err"}, 64'(out_err_w), 64'(m == 2'b11));
        tick();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        int acc, idx, stall;
        logic [7:0] xv;
        logic [15:0] dw;
        logic [1:0]  mw;

        rst = 1'b1; in_valid = 1'b0; in_mode = 2'b00; in_data = 8'h00; out_ready = 1'b0;
        in_valid_w = 1'b0; in_mode_w = 2'b00; in_data_w = 16'h0000; out_ready_w = 1'b1;

        // Model pins against hand-computed values.
        chk("model_b2g_2d", model(2'b00, 64'h2D, 8).d, 64'h3B);
        chk("model_g2b_3b", model(2'b01, 64'h3B, 8).d, 64'h2D);
        chk("model_ginc_80", model(2'b10, 64'h80, 8).d, 64'h00);
        chk("model_ginc_01", model(2'b10, 64'h01, 8).d, 64'h03);
        chk("model_ginc_8000", model(2'b10, 64'h8000, 16).d, 64'h0000);

        // Reset state.
        tick(); tick();
        @(negedge clk);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_data", 64'(out_data), 64'd0);
        chk("rst_out_mode", 64'(out_mode), 64'd0);
        chk("rst_out_err", 64'(out_err), 64'd0);
        chk("rst_out_valid_w", 64'(out_valid_w), 64'd0);
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_in_ready", 64'(in_ready), 64'd1);
        tick();

        // Directed single transactions.
        xact("b2g_2d",  2'b00, 8'h2D, 8'h3B, 1'b0);
        xact("g2b_3b",  2'b01, 8'h3B, 8'h2D, 1'b0);
        xact("ginc_80", 2'b10, 8'h80, 8'h00, 1'b0);
        xact("ginc_00", 2'b10, 8'h00, 8'h01, 1'b0);
        xact("ginc_01", 2'b10, 8'h01, 8'h03, 1'b0);
        xact("rsvd_a5", 2'b11, 8'hA5, 8'hA5, 1'b1);

        // Back-to-back sweeps: B2G of all values, then G2B of their Gray codes.
        out_ready = 1'b1; stall = 0;
        for (int x = 0; x < 256; x++) begin
            in_valid = 1'b1; in_mode = 2'b00; in_data = 8'(x);
            @(negedge clk);
            if (!in_ready) stall++;
            tick();
        end
        in_valid = 1'b0;
        tick(); tick(); tick();
        seen.delete();
        for (int x = 0; x < 256; x++) begin
            xv = 8'(x);
            in_valid = 1'b1; in_mode = 2'b01; in_data = xv ^ (xv >> 1);
            @(negedge clk);
            if (!in_ready) stall++;
            tick();
        end
        in_valid = 1'b0;
        tick(); tick(); tick();
        chk("sweep_stalls", 64'(stall), 64'd0);
        chk("sweep_count", 64'(seen.size()), 64'd256);
        for (int x = 0; x < 256 && x < seen.size(); x++) chk("roundtrip", 64'(seen[x]), 64'(x));

        // Backpressure: 5 stalled cycles offering 3 inputs.
        out_ready = 1'b0; seen.delete(); acc = 0; idx = 0;
        for (int c = 0; c < 5; c++) begin
            in_valid = (idx < 3); in_mode = 2'b00; in_data = vals[idx < 3 ? idx : 2];
            @(negedge clk);
            if (in_valid && in_ready) begin acc++; idx++; end
            tick();
        end
        @(negedge clk);
        chk("bp_accepted", 64'(acc), 64'd2);
        chk("bp_in_ready", 64'(in_ready), 64'd0);
        chk("bp_out_valid", 64'(out_valid), 64'd1);
        chk("bp_out_hold", 64'(out_data), 64'h01);
        tick();
        out_ready = 1'b1;
        for (int c = 0; c < 10 && idx < 3; c++) begin
            in_valid = 1'b1; in_data = vals[idx];
            @(negedge clk);
            if (in_ready) idx++;
            tick();
        end
        in_valid = 1'b0;
        tick(); tick(); tick(); tick();
        chk("bp_count", 64'(seen.size()), 64'd3);
        if (seen.size() == 3) begin
            chk("bp_out0", 64'(seen[0]), 64'h01);
            chk("bp_out1", 64'(seen[1]), 64'h03);
            chk("bp_out2", 64'(seen[2]), 64'h02);
        end

        // Reset with two transactions in flight.
        out_ready = 1'b0;
        for (int c = 0; c < 2; c++) begin
            in_valid = 1'b1; in_mode = 2'b00; in_data = 8'($urandom);
            tick();
        end
        in_valid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("mid_rst_out_valid", 64'(out_valid), 64'd0);
        chk("mid_rst_out_data", 64'(out_data), 64'd0);
        chk("mid_rst_out_err", 64'(out_err), 64'd0);
        chk("mid_rst_in_ready", 64'(in_ready), 64'd1);
        tick();
        out_ready = 1'b1;
        for (int c = 0; c < 5; c++) tick();

        // Randomized traffic with random backpressure.
        for (int c = 0; c < 3000; c++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            in_mode   = 2'($urandom);
            in_data   = 8'($urandom);
            out_ready = (c % 200 < 20) ? 1'b0 : ($urandom_range(0, 3) != 0);
            tick();
        end
        in_valid = 1'b0; out_ready = 1'b1;
        for (int c = 0; c < 5; c++) tick();
        chk("drained", 64'(q.size()), 64'd0);

        // WIDTH=16 instance.
        xact_w("w16_ginc_8000", 2'b10, 16'h8000, 16'h0000);
        xact_w("w16_ginc_0000", 2'b10, 16'h0000, 16'h0001);
        for (int c = 0; c < 20; c++) begin
            mw = 2'($urandom);
            dw = 16'($urandom);
            xact_w("w16_rand", mw, dw, 16'(model(mw, 64'(dw), 16).d));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
